// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, command bytes and the frame parity helper.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_RTS,
      ST_SHIFT,
      ST_ACK,
      ST_WAIT_IDLE
   } state_t;

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] RSP_ACK      = 8'hFA;

   // bitCnt value at the clock fall that releases data for the stop bit
   localparam logic [3:0] STOP_FALL_CNT = 4'd9;

   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronises the asynchronous PS/2 clock/data pad levels and produces a registered
// one-cycle pulse on each falling edge of the synchronised clock.
module ps2_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic ps2_clk_i,
   input  logic ps2_data_i,
   output logic clk_sync_o,
   output logic data_sync_o,
   output logic clk_fall_o
);

   logic [SYNC_STAGES-1:0] clk_sync_q;
   logic [SYNC_STAGES-1:0] data_sync_q;
   logic                   clk_prev_q;
   logic                   clk_fall_q;

   // Idle bus level is high, so the chains come out of reset high and report no edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         clk_sync_q  <= '1;
         data_sync_q <= '1;
         clk_prev_q  <= 1'b1;
         clk_fall_q  <= 1'b0;
      end else begin
         clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
         data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
         clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
         clk_fall_q  <= clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
      end
   end

   assign clk_sync_o  = clk_sync_q[SYNC_STAGES-1];
   assign data_sync_o = data_sync_q[SYNC_STAGES-1];
   assign clk_fall_o  = clk_fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift one command byte on
// device clock falls, then check the device ACK with an overall watchdog timeout.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 2500,
   parameter int TIMEOUT_CYCLES = 375000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       pixelClk,
   input  logic       reset,
   input  logic [7:0] txData,
   input  logic       txValid,
   output logic       txReady,
   input  logic       ps2ClkIn,
   input  logic       ps2DataIn,
   output logic       ps2ClkOe,
   output logic       ps2DataOe,
   output logic       busy,
   output logic       txDone,
   output logic       txErr
);

   localparam int IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IW-1:0] INHIBIT_LAST  = IW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_LIMIT = TW'(TIMEOUT_CYCLES);

   state_t        state_q, state_d;
   logic [8:0]    shift_q, shift_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [IW-1:0] inhib_cnt_q, inhib_cnt_d;
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          ack_ok_q, ack_ok_d;
   logic          clk_oe_q, clk_oe_d;
   logic          data_oe_q, data_oe_d;

   logic clk_sync, data_sync, clk_fall;
   logic timed, tmo_hit;
   logic done_pulse, err_pulse;

   ps2_line_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk_i      (pixelClk),
      .rst_ni     (reset),
      .ps2_clk_i  (ps2ClkIn),
      .ps2_data_i (ps2DataIn),
      .clk_sync_o (clk_sync),
      .data_sync_o(data_sync),
      .clk_fall_o (clk_fall)
   );

   assign timed   = (state_q == ST_SHIFT) || (state_q == ST_ACK) || (state_q == ST_WAIT_IDLE);
   assign tmo_hit = timed && (tmo_cnt_q == TIMEOUT_LIMIT);

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      inhib_cnt_d = inhib_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      ack_ok_d    = ack_ok_q;
      clk_oe_d    = clk_oe_q;
      data_oe_d   = data_oe_q;
      done_pulse  = 1'b0;
      err_pulse   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            tmo_cnt_d = '0;
            if (txValid) begin
               shift_d     = {odd_parity(txData), txData};
               inhib_cnt_d = '0;
               clk_oe_d    = 1'b1;
               state_d     = ST_INHIBIT;
            end
         end
         ST_INHIBIT: begin
            if (inhib_cnt_q == INHIBIT_LAST) begin
               data_oe_d = 1'b1;
               state_d   = ST_RTS;
            end else begin
               inhib_cnt_d = inhib_cnt_q + IW'(1);
            end
         end
         ST_RTS: begin
            clk_oe_d  = 1'b0;
            tmo_cnt_d = '0;
            bit_cnt_d = '0;
            state_d   = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (clk_fall) begin
               // Open-drain: a 0 bit is driven low, a 1 bit is released.
               if (bit_cnt_q == STOP_FALL_CNT) begin
                  data_oe_d = 1'b0;
                  state_d   = ST_ACK;
               end else begin
                  data_oe_d = ~shift_q[0];
                  shift_d   = {1'b0, shift_q[8:1]};
               end
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
         end
         ST_ACK: begin
            if (clk_fall) begin
               ack_ok_d = ~data_sync;
               state_d  = ST_WAIT_IDLE;
            end
         end
         ST_WAIT_IDLE: begin
            if (clk_sync && data_sync) begin
               done_pulse = ack_ok_q;
               err_pulse  = ~ack_ok_q;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (timed) begin
         tmo_cnt_d = tmo_cnt_q + TW'(1);
      end

      // The watchdog overrides a same-cycle ACK or completion.
      if (tmo_hit) begin
         state_d    = ST_IDLE;
         clk_oe_d   = 1'b0;
         data_oe_d  = 1'b0;
         done_pulse = 1'b0;
         err_pulse  = 1'b1;
      end
   end

   always_ff @(posedge pixelClk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         inhib_cnt_q <= '0;
         tmo_cnt_q   <= '0;
         ack_ok_q    <= 1'b0;
         clk_oe_q    <= 1'b0;
         data_oe_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         inhib_cnt_q <= inhib_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         ack_ok_q    <= ack_ok_d;
         clk_oe_q    <= clk_oe_d;
         data_oe_q   <= data_oe_d;
      end
   end

   assign txReady   = (state_q == ST_IDLE);
   assign busy      = ~txReady;
   assign ps2ClkOe  = clk_oe_q;
   assign ps2DataOe = data_oe_q & ~tmo_hit;
   assign txDone    = done_pulse;
   assign txErr     = err_pulse;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a PS/2 device model, an outcome scoreboard and a per-cycle checker.
`timescale 1ns/1ps
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INHIBIT = 2500;
   localparam int TIMEOUT = 1500;
   localparam int HALF    = 40;
   localparam int M_ACK = 0, M_NACK = 1, M_NONE = 2, M_RST = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] txData = 8'h00;
   logic       txValid = 1'b0;
   logic       txReady, ps2ClkOe, ps2DataOe, busy, txDone, txErr;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;
   logic       pad_clk, pad_data;

   int         n_vec = 0;
   int         n_err = 0;
   int         cyc = 0;
   bit         sb[$];
   logic [9:0] last_frame;
   logic       prev_pulse = 1'b0;

   assign pad_clk  = !(ps2ClkOe || dev_clk_low);
   assign pad_data = !(ps2DataOe || dev_data_low);

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INHIBIT),
      .TIMEOUT_CYCLES(TIMEOUT),
      .SYNC_STAGES(2)
   ) dut (
      .pixelClk (clk),
      .reset    (rst_n),
      .txData   (txData),
      .txValid  (txValid),
      .txReady  (txReady),
      .ps2ClkIn (pad_clk),
      .ps2DataIn(pad_data),
      .ps2ClkOe (ps2ClkOe),
      .ps2DataOe(ps2DataOe),
      .busy     (busy),
      .txDone   (txDone),
      .txErr    (txErr)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Per-cycle checker: handshake relations, idle lines, pulse shape, outcome scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("ready_vs_busy", txReady, !busy);
         chk("done_err_excl", txDone & txErr, 0);
         if (txReady) chk("idle_lines", {ps2ClkOe, ps2DataOe}, 0);
         chk("pulse_width", prev_pulse & (txDone | txErr), 0);
         if (txDone || txErr) begin
            if (sb.size() == 0) begin
               chk("unexpected_pulse", {txDone, txErr}, 0);
            end else begin
               chk("sb_outcome", {txDone, txErr}, sb.pop_front() ? 2'b10 : 2'b01);
            end
         end
         prev_pulse = txDone | txErr;
      end else begin
         prev_pulse = 1'b0;
      end
   end

   task automatic run(input logic [7:0] d, input int mode, input bit keep,
                      input logic [7:0] nxt, input bit pre);
      int         cnt;
      int         rel;
      bit         found;
      bit         exp_par;
      logic [9:0] obs;
      if (!pre) begin
         found = 0;
         for (int i = 0; i < 200; i++) begin
            if (txReady) begin found = 1; break; end
            @(negedge clk);
         end
         chk("ready_before_accept", found, 1);
         txData  = d;
         txValid = 1'b1;
         sb.push_back(mode == M_ACK);
         @(posedge clk);
         #1;
         if (keep) txData = nxt;
         else begin txValid = 1'b0; txData = 8'h00; end
         @(negedge clk);
         chk("busy_after_accept", {busy, txReady}, 2'b10);
      end
      cnt = 0;
      for (int i = 0; i < INHIBIT + 100; i++) begin
         if (ps2DataOe) break;
         if (ps2ClkOe) cnt++;
         @(negedge clk);
      end
      chk("inhibit_len", cnt, INHIBIT);
      found = 0;
      for (int i = 0; i < 10; i++) begin
         if (!ps2ClkOe) begin found = 1; break; end
         @(negedge clk);
      end
      chk("clk_release", found, 1);
      chk("start_bit", ps2DataOe, 1);
      rel = cyc;
      obs = '0;
      if (mode != M_NONE) begin
         repeat (20) @(posedge clk);
         for (int k = 1; k <= 11; k++) begin
            if (k == 11) begin
               dev_data_low = (mode == M_ACK);
               repeat (HALF) @(posedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (HALF) @(posedge clk);
            @(negedge clk);
            if (k <= 10) obs[k-1] = pad_data;
            dev_clk_low = 1'b0;
            if (k == 11) dev_data_low = 1'b0;
            else repeat (HALF) @(posedge clk);
            if (mode == M_RST && k == 4) break;
         end
      end
      if (mode == M_RST) begin
         @(negedge clk);
         chk("pre_reset_data_oe", ps2DataOe, 1);
         #3 rst_n = 1'b0;
         sb.delete();
         #1;
         chk("reset_oe", {ps2ClkOe, ps2DataOe}, 0);
         chk("reset_ready", {txReady, busy}, 2'b10);
         repeat (4) @(negedge clk);
         rst_n = 1'b1;
         @(negedge clk);
         chk("ready_after_reset", txReady, 1);
         $display("txn %02h: reset after 4 data bits, lines released", d);
         return;
      end
      found = 0;
      for (int i = 0; i < TIMEOUT + 200; i++) begin
         if (txDone || txErr) begin found = 1; break; end
         @(negedge clk);
      end
      chk("pulse_seen", found, 1);
      if (mode == M_NONE) chk("timeout_cycles", cyc - rel, TIMEOUT);
      chk("outcome", {txDone, txErr}, (mode == M_ACK) ? 2'b10 : 2'b01);
      chk("oe_at_end", {ps2ClkOe, ps2DataOe}, 0);
      if (mode != M_NONE) begin
         exp_par = ($countones(d) % 2 == 0);
         chk($sformatf("frame_%02h", d), obs, {1'b1, exp_par, d});
      end
      last_frame = obs;
      $display("txn %02h mode %0d: frame %03h, done %0b err %0b, %0d cycles after release",
               d, mode, obs, txDone, txErr, cyc - rel);
      @(negedge clk);
      chk("pulse_over", {txDone, txErr}, 0);
      chk("ready_after_end", txReady, 1);
      if (keep) begin
         sb.push_back(1'b1);
         @(posedge clk);
         #1 txValid = 1'b0;
         @(negedge clk);
         chk("back_to_back_accept", busy, 1);
      end
   endtask

   initial begin
      repeat (95000) @(posedge clk);
      $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] pd [4];
      bit         pp [4];
      pd = '{8'h00, 8'h01, 8'hFF, 8'hFA};
      pp = '{1'b1, 1'b0, 1'b1, 1'b1};

      repeat (3) @(negedge clk);
      chk("reset_state", {txReady, busy, ps2ClkOe, ps2DataOe, txDone, txErr}, 6'b100000);
      rst_n = 1'b1;
      @(negedge clk);

      run(CMD_SET_LEDS, M_ACK, 0, 8'h00, 0);
      chk("ED_literal", last_frame, 10'h3ED);

      for (int i = 0; i < 4; i++) begin
         run(pd[i], M_ACK, 0, 8'h00, 0);
         chk("parity_literal", last_frame[8], pp[i]);
      end

      run(CMD_ENABLE, M_NACK, 0, 8'h00, 0);
      run(CMD_RESET, M_NONE, 0, 8'h00, 0);
      run(CMD_ENABLE, M_RST, 0, 8'h00, 0);
      run(CMD_ENABLE, M_ACK, 0, 8'h00, 0);
      chk("F4_literal", last_frame, 10'h2F4);

      run(CMD_ENABLE, M_ACK, 1, CMD_RESET, 0);
      chk("F4_held_literal", last_frame, 10'h2F4);
      run(CMD_RESET, M_ACK, 0, 8'h00, 1);
      chk("FF_literal", last_frame, 10'h3FF);

      repeat (5) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
